// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   state_t     : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W_DEF  : default data word width
//   WORD_SHIFT  : byte address -> word index shift
//   WAIT_CNT_W  : width of the wait-state counter (WAIT_CYCLES 0..15)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int WORD_SHIFT = 2;
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// DEPTH x DATA_W word storage. Contents are never reset.
// Ports:
//   clock : write clock (rising edge)
//   we    : write enable
//   widx  : write word index
//   wdata : write data
//   ridx  : read word index (asynchronous read)
//   rdata : read data, combinational from ridx
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Word-addressed data-memory responder for the CPU load/store port.
// A request is accepted in IDLE, held for WAIT_CYCLES wait states, and
// completed with a one-cycle ack in RESP. Stores write the array and loads
// capture rdata on the edge that enters RESP.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN -- when defined, accesses
// with addr[1:0] != 0 are rejected (store dropped, load returns 0, err=1).
// Ports:
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   req    : access request, held until ack
//   we     : 1 = store, 0 = load
//   addr   : byte address
//   wdata  : store data
//   ack    : one-cycle completion pulse
//   rdata  : load data, held until the next load completes
//   busy   : high whenever the FSM is not IDLE
//   err    : out-of-range (or misaligned) access, valid with ack
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int FULL_W = ADDR_W - WORD_SHIFT;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  state_t                state_reg;
  logic [WAIT_CNT_W-1:0] cnt_reg;
  logic                  we_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic                  ack_reg;
  logic                  err_reg;
  logic [DATA_W-1:0]     rdata_reg;

  // Attributes of the access being completed. With zero wait states the
  // RESP-entry edge is the accept edge itself, so the live inputs are used
  // while in IDLE; otherwise the registered copies are used.
  logic                  acc_we;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic [FULL_W-1:0]     full_idx;
  logic                  in_range;
  logic                  acc_err;
  logic                  enter_resp;
  logic                  mem_we;
  logic [DATA_W-1:0]     rd_word;

  always_comb begin
    acc_we     = we_reg;
    acc_addr   = addr_reg;
    acc_wdata  = wdata_reg;
    enter_resp = 1'b0;
    if (state_reg == IDLE) begin
      acc_we     = we;
      acc_addr   = addr;
      acc_wdata  = wdata;
      enter_resp = req && (WAIT_CYCLES == 0);
    end else if (state_reg == WAIT) begin
      enter_resp = (cnt_reg == CNT_ONE);
    end
  end

  assign full_idx = acc_addr[ADDR_W-1:WORD_SHIFT];
  assign in_range = (32'(full_idx) < 32'(DEPTH));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_err = !in_range || (acc_addr[WORD_SHIFT-1:0] != '0);
`else
  // Byte offset is deliberately ignored: truncating word access.
  logic unused_offset;
  assign unused_offset = ^acc_addr[WORD_SHIFT-1:0];
  assign acc_err = !in_range;
`endif

  // Gate with resetn so a store can never land while reset is asserted.
  assign mem_we = enter_resp && acc_we && !acc_err && resetn;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .widx  (full_idx[IDX_W-1:0]),
    .wdata (acc_wdata),
    .ridx  (full_idx[IDX_W-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg    <= we;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            cnt_reg   <= WAIT_INIT;
            state_reg <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
      // ack/err are high exactly while in RESP.
      if (enter_resp) begin
        ack_reg <= 1'b1;
        err_reg <= acc_err;
        if (!acc_we) begin
          rdata_reg <= acc_err ? '0 : rd_word;
        end
      end
    end
  end

  assign busy  = (state_reg != IDLE);
  assign ack   = ack_reg;
  assign err   = err_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed, table-driven bench for dmem_responder. Three instances share
// clock and resetn: WAIT_CYCLES = 1 (main vector table), 0 (back-to-back
// held req) and 3 (reset in the middle of a store).
module tb_dmem_responder;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  // WAIT_CYCLES = 1 instance
  logic req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0, wdata1 = '0;
  logic ack1, busy1, err1;
  logic [15:0] rdata1;

  // WAIT_CYCLES = 0 instance
  logic req0 = 1'b0, we0 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0;
  logic ack0, busy0, err0;
  logic [15:0] rdata0;

  // WAIT_CYCLES = 3 instance
  logic req3 = 1'b0, we3 = 1'b0;
  logic [15:0] addr3 = '0, wdata3 = '0;
  logic ack3, busy3, err3;
  logic [15:0] rdata3;

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clock(clock), .resetn(resetn), .req(req1), .we(we1), .addr(addr1),
    .wdata(wdata1), .ack(ack1), .rdata(rdata1), .busy(busy1), .err(err1));

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .resetn(resetn), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0));

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clock(clock), .resetn(resetn), .req(req3), .we(we3), .addr(addr3),
    .wdata(wdata3), .ack(ack3), .rdata(rdata3), .busy(busy3), .err(err3));

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=1 instance. lat counts falling edges after
  // the accept edge up to and including the one that sees ack.
  task automatic run1(input vec_t v, output int lat, output int bcnt,
                      output logic e, output logic [15:0] rd, output logic pulse_ok);
    @(negedge clock);
    req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    lat = 0; bcnt = 0;
    @(posedge clock);
    do begin
      @(negedge clock);
      lat++;
      if (busy1) bcnt++;
    end while (!ack1 && lat < 20);
    e = err1; rd = rdata1;
    req1 = 1'b0;
    @(negedge clock);
    pulse_ok = !ack1 && !busy1;
  endtask

  task automatic run3(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output logic e, output logic [15:0] rd);
    @(negedge clock);
    req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d;
    lat = 0;
    @(posedge clock);
    do begin
      @(negedge clock);
      lat++;
    end while (!ack3 && lat < 20);
    e = err3; rd = rdata3;
    req3 = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int lat, bcnt, n_ack;
    logic e, pulse_ok, prev_ack;
    logic [15:0] rd;

    //         we    addr      wdata     exp_rdata                exp_err
    vecs[0]  = '{1'b1, 16'h0000, 16'h0005, 16'h0000,               1'b0};
    vecs[1]  = '{1'b1, 16'h0004, 16'h0007, 16'h0000,               1'b0};
    vecs[2]  = '{1'b0, 16'h0004, 16'h0000, 16'h0007,               1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 16'h0005,               1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0005,               1'b0};
    vecs[5]  = '{1'b0, 16'h0004, 16'h0000, 16'h0007,               1'b0};
    vecs[6]  = '{1'b1, 16'h0004, 16'h0005, 16'h0007,               1'b0};
    vecs[7]  = '{1'b1, 16'h0000, 16'h0007, 16'h0007,               1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0007,               1'b0};
    vecs[9]  = '{1'b0, 16'h0004, 16'h0000, 16'h0005,               1'b0};
    vecs[10] = '{1'b1, 16'h1000, 16'hBEEF, 16'h0005,               1'b1};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 16'h0007,               1'b0};
    vecs[12] = '{1'b0, 16'h1000, 16'h0000, 16'h0000,               1'b1};
    vecs[13] = '{1'b1, 16'h0FFC, 16'h1357, 16'h0000,               1'b0};
    vecs[14] = '{1'b0, 16'h0FFC, 16'h0000, 16'h1357,               1'b0};
    vecs[15] = '{1'b1, 16'h0002, 16'h00AA, 16'h1357,               MIS};
    vecs[16] = '{1'b0, 16'h0000, 16'h0000, MIS ? 16'h0007 : 16'h00AA, 1'b0};
    vecs[17] = '{1'b0, 16'h0006, 16'h0000, MIS ? 16'h0000 : 16'h0005, MIS};
    vecs[18] = '{1'b1, 16'hFFFC, 16'h4444, MIS ? 16'h0000 : 16'h0005, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("reset_ack1",   {31'd0, ack1},  32'd0);
    chk("reset_busy1",  {31'd0, busy1}, 32'd0);
    chk("reset_err1",   {31'd0, err1},  32'd0);
    chk("reset_rdata1", {16'd0, rdata1}, 32'd0);
    chk("reset_busy0",  {31'd0, busy0}, 32'd0);
    chk("reset_rdata3", {16'd0, rdata3}, 32'd0);

    // Main vector table, WAIT_CYCLES = 1: ack two falling edges after accept
    for (int i = 0; i < NVEC; i++) begin
      run1(vecs[i], lat, bcnt, e, rd, pulse_ok);
      $display("vec %0d we=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, e, rd);
      chk($sformatf("v%0d_latency", i), lat, 32'd2);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd2);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      chk($sformatf("v%0d_single_ack", i), {31'd0, pulse_ok}, 32'd1);
    end

    // rdata holds between accesses
    repeat (3) @(negedge clock);
    chk("rdata_hold", {16'd0, rdata1}, {16'd0, vecs[NVEC-1].exp_rdata});

    // WAIT_CYCLES = 0: store, then a load with req held continuously
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0000; wdata0 = 16'h0055;
    @(negedge clock);
    chk("w0_store_ack", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
    n_ack = 0;
    prev_ack = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      $display("w0 cycle %0d ack=%0b rdata=%h", k, ack0, rdata0);
      chk($sformatf("w0_ack_c%0d", k), {31'd0, ack0}, {31'd0, k[0]});
      if (ack0) begin
        n_ack++;
        chk($sformatf("w0_rdata_c%0d", k), {16'd0, rdata0}, 32'h0055);
        chk($sformatf("w0_no_consec_c%0d", k), {31'd0, prev_ack}, 32'd0);
      end
      prev_ack = ack0;
    end
    req0 = 1'b0;
    chk("w0_ack_count", n_ack, 32'd6);

    // WAIT_CYCLES = 3: store known value, then abort a second store by reset
    run3(1'b1, 16'h0008, 16'h0A0A, lat, e, rd);
    $display("w3 store addr=0008 wdata=0A0A -> lat=%0d err=%0b", lat, e);
    chk("w3_store_latency", lat, 32'd4);
    chk("w3_store_err", {31'd0, e}, 32'd0);

    @(negedge clock);
    req3 = 1'b1; we3 = 1'b1; addr3 = 16'h0008; wdata3 = 16'h1234;
    @(posedge clock);
    @(negedge clock);
    chk("w3_busy_before_reset", {31'd0, busy3}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("w3_busy_in_reset", {31'd0, busy3}, 32'd0);
    chk("w3_ack_in_reset", {31'd0, ack3}, 32'd0);
    req3 = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    n_ack = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack3) n_ack++;
    end
    chk("w3_no_ack_after_abort", n_ack, 32'd0);

    run3(1'b0, 16'h0008, 16'h0000, lat, e, rd);
    $display("w3 load addr=0008 -> lat=%0d err=%0b rdata=%h", lat, e, rd);
    chk("w3_load_latency", lat, 32'd4);
    chk("w3_load_rdata", {16'd0, rd}, 32'h0A0A);
    chk("w3_load_err", {31'd0, e}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed 16-bit data-memory responder. It serves the CPU's load/store port over a req/ack handshake with a configurable number of wait states.
- It sits between the CPU datapath (the ALUOut byte address, RD2 store data and the MemWrite/MemtoReg path) and the storage array.
- It replaces the CPU's zero-latency internal DMemory array so that the CPU can later be moved to a multi-cycle or stalling core.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 16: byte-address width from the CPU.
- DEPTH, 1024: number of words; word index = addr >> 2.
- WAIT_CYCLES, 1: wait states inserted between acceptance and ack; range 0..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  access request; held high by the initiator until ack.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  ADDR_W  byte address; sampled with req.
- wdata  in  DATA_W  store data; sampled with req.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  load data; valid while ack is high, held until the next load completes.
- busy  out  1  high whenever state != IDLE.
- err  out  1  access error; valid only while ack is high.

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE; wait counter = 0.
  - ack = 0, busy = 0, err = 0, rdata = 0.
  - Memory contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req is high at a clock edge, register addr, we and wdata, and load the counter with WAIT_CYCLES.
  - Go to RESP if WAIT_CYCLES == 0, otherwise to WAIT.
  - If req is low, stay in IDLE.
- WAIT:
  - Decrement the counter each edge.
  - When the counter is 1 at an edge, go to RESP.
  - req, addr, we and wdata are ignored in this state; the registered copies are used.
- RESP:
  - ack = 1 for exactly one cycle, then unconditionally return to IDLE.
  - A req still high in the IDLE cycle after ack is treated as a new request. The initiator must drop req in the cycle ack is seen unless it is issuing a back-to-back access.
- Latency: ack is high in cycle WAIT_CYCLES+1, counting the accept edge as cycle 0. Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Word index is registered addr >> 2. addr[1:0] is ignored unless the optional feature is enabled.
- Store:
  - The array is written on the edge that enters RESP.
  - rdata is unchanged by a store.
- Load:
  - rdata is registered from the array on the edge that enters RESP.
  - The load observes any store that completed on an earlier access.
- Out of range (index >= DEPTH):
  - A store is dropped; a load returns 0.
  - err = 1 with ack.
  - The access still completes normally, with no hang.
- Reset mid-access: a store whose RESP-entry edge has not yet occurred is aborted and the memory is unchanged. No ack is produced.
- busy is combinational from state; ack and err are registered, decoded from state RESP.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined: an access with addr[1:0] != 2'b00 is rejected.
  - A store is dropped; a load returns 0.
  - err = 1 with ack.
  - Latency is unchanged.
- Undefined: addr[1:0] is silently ignored (truncating word access), and err reflects the out-of-range condition only.

Decomposition:
- Package dmem_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - DATA_W_DEF = 16 and WORD_SHIFT = 2;
  - the counter width constant WAIT_CNT_W = 4.
- Sub-module dmem_array (DEPTH x DATA_W storage):
  - synchronous write port (we, index, data);
  - asynchronous read port;
  - no reset.
- dmem_responder holds the FSM, counter, request registers and range/alignment checks.

Test Plan:
- Reset, then store 0x0005 @addr 0 and 0x0007 @addr 4 with WAIT_CYCLES=1 -> each ack pulses exactly in cycle 2 after accept, err=0, busy high for 2 cycles.
- Load @4 then load @0 -> rdata = 0x0007 then 0x0005, each valid with its ack; rdata holds 0x0005 afterwards.
- Swap sequence (load 0, load 4, store 4←0x0005, store 0←0x0007, load 0, load 4) -> final loads return 0x0007 and 0x0005.
- WAIT_CYCLES=0, req held high continuously with a load @0 -> ack every 2nd cycle, never on consecutive cycles.
- Store 0xBEEF @addr 4096 (index 1024) -> ack with err=1; a subsequent load @0 still returns the prior value. With DMEM_MISALIGN_CHECK_EN, a store @addr 2 -> err=1 and word 0 unchanged; without it, word 0 = written data.
- Assert resetn low one cycle after accepting a store 0x1234 @8 with WAIT_CYCLES=3 -> no ack, busy=0 immediately; a later load @8 returns the pre-reset contents.
